coin_bank: RTL
==============

# coin_bank

Coin-stock manager for the change-dispensing datapath: holds per-denomination coin counts (50, 20, 10, 5) and accepts coin inserts. On request it dispenses change greedily, one coin per cycle. Sits directly upstream of the thermometer display decoder. It drives that decoder's one-hot denomination select and the four 9-bit count buses.

## Interface
- MAX_CNT, 8: maximum coins per denomination (display decoder range is 0..8)
- INIT_CNT, 4: count loaded into every denomination on reset

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- coin_in  in  4  one-cycle insert pulse, one-hot {50,20,10,5} = bits [3:0]
- change_req  in  1  one-cycle change request pulse
- change_amt  in  8  change amount in currency units, sampled with change_req
- sel_next  in  1  one-cycle pulse, advances display select
- C50, C20, C10, C5  out  9  current coin counts, 0..MAX_CNT, upper bits zero
- S  out  4  one-hot display select {50,20,10,5}
- coin_out  out  4  one-cycle one-hot pulse per dispensed coin
- busy  out  1  high while dispensing
- done  out  1  one-cycle pulse, change fully dispensed
- err  out  1  one-cycle pulse, change cannot be paid, stock restored
- insert_rej  out  1  one-cycle pulse, insert refused

## Operation
- All outputs are registered. Reset values:
  - C50/C20/C10/C5 = INIT_CNT
  - S = 4'b1000
  - coin_out = 0, busy = 0, done = 0, err = 0, insert_rej = 0
- FSM states: IDLE, DISP.
- IDLE:
  - A valid one-hot coin_in increments the matching count.
  - insert_rej pulses instead if the count is already MAX_CNT, coin_in is not one-hot, or change_req is also high that cycle (change_req wins).
  - change_req: latch change_amt into 8-bit rem, snapshot all four counts, go to DISP.
- DISP, evaluated once per cycle:
  - rem == 0: pulse done, go to IDLE.
  - Otherwise pick the largest denomination d with d <= rem and count > 0, checking 50, 20, 10, 5 in that order. Decrement that count, subtract d from rem, and pulse the matching coin_out bit.
  - No denomination qualifies (including any rem < 5, or rem not a multiple of 5): restore all counts from the snapshot, pulse err, go to IDLE.
- Greedy only: no backtracking. A request that a non-greedy mix could pay but greedy cannot reports err.
- In DISP, any nonzero coin_in pulses insert_rej and is dropped. change_req is ignored with no flag.
- S rotates right on sel_next in any state: 1000→0100→0010→0001→1000. Rotation is independent of the FSM.
- Counts never exceed MAX_CNT and never underflow.

## Timing
- change_req sampled at edge k: busy = 1 from edge k.
- Request needing n coins:
  - coin_out pulses after edges k+1..k+n, each with its count decrement on the same edge.
  - done = 1 and busy = 0 after edge k+n+1.
- change_amt = 0: done after edge k+1, no coin_out.
- Failure at evaluation edge j: err = 1, counts equal the snapshot, busy = 0, all after edge j. coin_out pulses already issued stand.
- insert_rej and count increments appear one edge after coin_in.
- rst mid-dispense: next edge forces reset values and abandons the request. No done or err pulse.
- Counts change at most once per edge.

## Test plan
- Reset -> all counts = 4; S = 1000; outputs 0. Then sel_next ×4 -> S walks 0100, 0010, 0001, 1000.
- Five inserts of 50 from count 4 -> counts 5, 6, 7, 8, then insert_rej on the 5th with C50 staying 8. coin_in = 4'b0110 -> insert_rej, no count change.
- Reset counts, change_amt = 85 -> coin_out 1000, 0100, 0010, 0001 on consecutive cycles. done after edge k+5. Counts 3/3/3/3.
- Set C50 = 1, C20 = 3, C10 = 0, C5 = 0; change_amt = 60 -> one coin_out 1000, then err. Counts restored to 1/3/0/0, busy = 0.
- change_amt = 7 with full stock -> 5 dispensed, then err with rem 2. Stock restored. change_amt = 0 -> done after edge k+1 with no coin_out.
- change_amt = 100 with default stock, coin_in asserted mid-dispense -> insert_rej. Asserting rst after the first coin_out -> counts back to 4, busy = 0, no done or err.

Source files
------------

// File: rtl/coin_bank.sv
// Coin-stock manager: per-denomination counts (50/20/10/5), coin inserts, and greedy
// one-coin-per-cycle change dispensing with snapshot restore on failure.
module coin_bank #(
  parameter int unsigned MAX_CNT  = 8,
  parameter int unsigned INIT_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] coin_in,
  input  logic       change_req,
  input  logic [7:0] change_amt,
  input  logic       sel_next,
  output logic [8:0] C50,
  output logic [8:0] C20,
  output logic [8:0] C10,
  output logic [8:0] C5,
  output logic [3:0] S,
  output logic [3:0] coin_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       insert_rej
);

  localparam int unsigned CntW = 9;

  typedef enum logic {StIdle, StDisp} state_e;

  // Index 3..0 maps to denominations 50, 20, 10, 5.
  function automatic logic [7:0] denom(input logic [1:0] idx);
    case (idx)
      2'd3:    denom = 8'd50;
      2'd2:    denom = 8'd20;
      2'd1:    denom = 8'd10;
      default: denom = 8'd5;
    endcase
  endfunction

  state_e                     state_q, state_d;
  logic [7:0]                 rem_q, rem_d;
  logic [3:0][CntW-1:0]       cnt_q, cnt_d;
  logic [3:0][CntW-1:0]       snap_q, snap_d;
  logic [3:0]                 sel_q, sel_d;
  logic [3:0]                 coin_out_q, coin_out_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       rej_q, rej_d;
  logic                       found;
  logic [1:0]                 pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      cnt_q      <= {4{CntW'(INIT_CNT)}};
      snap_q     <= {4{CntW'(INIT_CNT)}};
      sel_q      <= 4'b1000;
      coin_out_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      sel_q      <= sel_d;
      coin_out_q <= coin_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rej_q      <= rej_d;
    end
  end

  // Largest stocked denomination not exceeding the remaining amount.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!found && cnt_q[i] != '0 && denom(2'(i)) <= rem_q) begin
        found = 1'b1;
        pick  = 2'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    sel_d      = sel_next ? {sel_q[0], sel_q[3:1]} : sel_q;
    coin_out_d = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rej_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (change_req) begin
          rem_d   = change_amt;
          snap_d  = cnt_q;
          state_d = StDisp;
          rej_d   = (coin_in != '0);
        end else if ($onehot(coin_in)) begin
          for (int i = 0; i < 4; i++) begin
            if (coin_in[i]) begin
              if (cnt_q[i] < CntW'(MAX_CNT)) cnt_d[i] = cnt_q[i] + CntW'(1);
              else                           rej_d    = 1'b1;
            end
          end
        end else if (coin_in != '0) begin
          rej_d = 1'b1;
        end
      end
      StDisp: begin
        rej_d = (coin_in != '0);
        if (rem_q == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (found) begin
          cnt_d[pick]      = cnt_q[pick] - CntW'(1);
          rem_d            = rem_q - denom(pick);
          coin_out_d[pick] = 1'b1;
        end else begin
          cnt_d   = snap_q;
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign C50        = cnt_q[3];
  assign C20        = cnt_q[2];
  assign C10        = cnt_q[1];
  assign C5         = cnt_q[0];
  assign S          = sel_q;
  assign coin_out   = coin_out_q;
  assign busy       = (state_q == StDisp);
  assign done       = done_q;
  assign err        = err_q;
  assign insert_rej = rej_q;

endmodule
